// File: rtl/dither_pkg.sv
// Shared types and constants for the dither sequencer: FSM encoding, mute level,
// default word width and the attenuation stepping helper.
package dither_pkg;

    localparam int DW_DEF = 11;

    // Attenuation of 8 forces the output to zero.
    localparam logic [3:0] ATT_MUTE = 4'd8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEED      = 3'd1,
        RAMP_UP   = 3'd2,
        ACTIVE    = 3'd3,
        RAMP_DOWN = 3'd4
    } state_t;

    // One attenuation step toward the target; holds when already there.
    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
        logic [3:0] res;
        res = cur;
        if (cur < tgt) begin
            res = cur + 4'd1;
        end else if (cur > tgt) begin
            res = cur - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dither_sequencer_if.sv
// Bundle of configuration, request and dither signals between the modulator side
// (master) and the dither sequencer (slave).
interface dither_sequencer_if #(
    parameter int DW = dither_pkg::DW_DEF
);
    logic signed [DW-1:0] dith_i;
    logic                 cfg_en;
    logic [2:0]           cfg_shift;
    logic                 sample_req;
    logic signed [DW-1:0] dith_o;
    logic                 dith_valid;
    logic                 lfsr_rst;
    logic [2:0]           state_o;
    logic                 busy;

    modport master (
        output dith_i, cfg_en, cfg_shift, sample_req,
        input  dith_o, dith_valid, lfsr_rst, state_o, busy
    );

    modport slave (
        input  dith_i, cfg_en, cfg_shift, sample_req,
        output dith_o, dith_valid, lfsr_rst, state_o, busy
    );
endinterface

// File: rtl/dither_scale.sv
// Dither datapath: optional first-order high-pass shaping (DITHER_HP_SHAPE_EN),
// arithmetic right-shift attenuation with mute, registered output and valid pulse.
module dither_scale
    import dither_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req,
    input  logic                 idle,
    input  logic [3:0]           att,
    input  logic signed [DW-1:0] dith_in,
    output logic signed [DW-1:0] dith_out,
    output logic                 dith_valid
);

    logic signed [DW-1:0] src;

`ifdef DITHER_HP_SHAPE_EN
    logic signed [DW-1:0] prev_reg;
    logic signed [DW:0]   diff;
    logic                 unused_lsb;

    // Difference is taken one bit wider so it cannot wrap, then halved back to DW bits.
    assign diff       = {dith_in[DW-1], dith_in} - {prev_reg[DW-1], prev_reg};
    assign src        = diff[DW:1];
    assign unused_lsb = diff[0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg <= '0;
        end else if (idle) begin
            prev_reg <= '0;
        end else if (req) begin
            prev_reg <= dith_in;
        end
    end
`else
    logic unused_idle;

    assign unused_idle = idle;
    assign src         = dith_in;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dith_out   <= '0;
            dith_valid <= 1'b0;
        end else begin
            dith_valid <= req;
            if (req) begin
                dith_out <= (att >= ATT_MUTE) ? '0 : (src >>> att);
            end
        end
    end

endmodule

// File: rtl/dither_sequencer.sv
// Dither sequencer: seeds the generator on enable, ramps attenuation in steps of
// RAMP_STEP serviced requests, and gates scaled dither onto sample requests.
// Optional high-pass shaping in the datapath is enabled by DITHER_HP_SHAPE_EN.
module dither_sequencer
    import dither_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int RAMP_STEP = 64,
    parameter int SEED_CYC  = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    dither_sequencer_if.slave bus
);

    localparam int CW = (RAMP_STEP > 1) ? $clog2(RAMP_STEP + 1) : 1;
    localparam int SW = (SEED_CYC > 1) ? $clog2(SEED_CYC + 1) : 1;

    state_t        state_reg, state_next;
    logic [3:0]    att_reg, att_next;
    logic [CW-1:0] step_reg, step_next;
    logic [SW-1:0] seed_reg, seed_next;
    logic          lfsr_rst_reg;
    logic          busy_reg;
    logic [3:0]    target;
    logic          step_hit;

    assign target   = {1'b0, bus.cfg_shift};
    assign step_hit = bus.sample_req && (step_reg == CW'(RAMP_STEP - 1));

    always_comb begin
        state_next = state_reg;
        att_next   = att_reg;
        step_next  = step_reg;
        seed_next  = seed_reg;
        case (state_reg)
            IDLE: begin
                att_next = ATT_MUTE;
                if (bus.cfg_en) begin
                    state_next = SEED;
                    seed_next  = SW'(SEED_CYC);
                end
            end
            SEED: begin
                if (!bus.cfg_en) begin
                    state_next = IDLE;
                end else begin
                    seed_next = seed_reg - SW'(1);
                    if (seed_reg <= SW'(1)) begin
                        state_next = RAMP_UP;
                    end
                end
            end
            RAMP_UP: begin
                if (!bus.cfg_en) begin
                    state_next = RAMP_DOWN;
                end else if (att_reg <= target) begin
                    // Covers a retarget at or above the current level; ACTIVE resolves the rest.
                    state_next = ACTIVE;
                end else if (bus.sample_req) begin
                    if (step_hit) begin
                        step_next = '0;
                        att_next  = att_reg - 4'd1;
                    end else begin
                        step_next = step_reg + CW'(1);
                    end
                end
            end
            ACTIVE: begin
                if (!bus.cfg_en) begin
                    state_next = RAMP_DOWN;
                end else if (att_reg == target) begin
                    step_next = '0;
                end else if (bus.sample_req) begin
                    if (step_hit) begin
                        step_next = '0;
                        att_next  = step_toward(att_reg, target);
                    end else begin
                        step_next = step_reg + CW'(1);
                    end
                end
            end
            RAMP_DOWN: begin
                if (bus.cfg_en) begin
                    state_next = RAMP_UP;
                end else if (att_reg >= ATT_MUTE) begin
                    state_next = IDLE;
                end else if (bus.sample_req) begin
                    if (step_hit) begin
                        step_next = '0;
                        att_next  = att_reg + 4'd1;
                    end else begin
                        step_next = step_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                att_next   = ATT_MUTE;
            end
        endcase
        if (state_next != state_reg) begin
            step_next = '0;
        end
    end

    // lfsr_rst and busy are decoded from the next state so they change with state_o.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            att_reg      <= ATT_MUTE;
            step_reg     <= '0;
            seed_reg     <= '0;
            lfsr_rst_reg <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            att_reg      <= att_next;
            step_reg     <= step_next;
            seed_reg     <= seed_next;
            lfsr_rst_reg <= (state_next == IDLE) || (state_next == SEED);
            busy_reg     <= (state_next == SEED) || (state_next == RAMP_UP) ||
                            (state_next == RAMP_DOWN);
        end
    end

    assign bus.lfsr_rst = lfsr_rst_reg;
    assign bus.busy     = busy_reg;
    assign bus.state_o  = state_reg;

    dither_scale #(
        .DW(DW)
    ) u_scale (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (bus.sample_req),
        .idle      (state_reg == IDLE),
        .att       (att_reg),
        .dith_in   (bus.dith_i),
        .dith_out  (bus.dith_o),
        .dith_valid(bus.dith_valid)
    );

endmodule

// File: tb/tb_dither_sequencer.sv
// Scoreboard bench for dither_sequencer: stimulus pushes expected samples computed
// from ramp arithmetic, a monitor pops and compares on every dith_valid pulse.
module tb_dither_sequencer;
    import dither_pkg::*;

    localparam int DW = 11;
    localparam int RS = 4;
    localparam int SC = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    dither_sequencer_if #(.DW(DW)) bus();

    dither_sequencer #(
        .DW(DW), .RAMP_STEP(RS), .SEED_CYC(SC)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int total = 0;
    int bad = 0;
    logic signed [DW-1:0] exp_q[$];
    logic signed [DW-1:0] prev_m = '0;
    bit m_idle = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Attenuation seen by the k-th serviced request of a ramp from start to target.
    function automatic int ramp_att(input int start, input int tgt, input int k);
        int a;
        if (tgt < start) begin
            a = start - k / RS;
            if (a < tgt) a = tgt;
        end else begin
            a = start + k / RS;
            if (a > tgt) a = tgt;
        end
        return a;
    endfunction

    task automatic send(input logic signed [DW-1:0] d, input int att);
        logic signed [DW-1:0] src;
        logic signed [DW-1:0] e;
`ifdef DITHER_HP_SHAPE_EN
        logic signed [DW:0] diff;
        diff = {d[DW-1], d} - {prev_m[DW-1], prev_m};
        src = diff[DW:1];
        prev_m = m_idle ? '0 : d;
`else
        src = d;
`endif
        e = (att >= 8) ? '0 : (src >>> att);
        exp_q.push_back(e);
        bus.sample_req = 1'b1;
        bus.dith_i = d;
        tick();
        bus.sample_req = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic ramp(input int start, input int tgt, input int n, input bit rnd,
                        input logic signed [DW-1:0] fixed_d);
        logic signed [DW-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = rnd ? DW'($urandom) : fixed_d;
            send(d, ramp_att(start, tgt, k));
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc, input string name);
        int n;
        n = 0;
        while (bus.state_o !== s && n < maxc) begin
            tick();
            n++;
        end
        chk(name, 32'(bus.state_o), 32'(s));
    endtask

    always @(negedge clock) begin
        if (reset_n && bus.dith_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got dith_o %0h with no request pending at %0t",
                         bus.dith_o, $time);
            end else begin
                chk("dith_o", 32'(bus.dith_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lfsr_hits;
        int valid_hits;
        bus.dith_i = '0;
        bus.cfg_en = 1'b0;
        bus.cfg_shift = 3'd0;
        bus.sample_req = 1'b0;
        repeat (3) tick();
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_lfsr", 32'(bus.lfsr_rst), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_dith_o", 32'(bus.dith_o), 32'd0);
        chk("rst_valid", 32'(bus.dith_valid), 32'd0);
        reset_n = 1'b1;
        tick();

        // Enable, seed for exactly SC cycles, ramp 8 -> 2 with fixed -1024.
        bus.cfg_shift = 3'd2;
        bus.cfg_en = 1'b1;
        m_idle = 1'b0;
        tick();
        chk("seed_lfsr_c1", 32'(bus.lfsr_rst), 32'd1);
        chk("seed_state", 32'(bus.state_o), 32'd1);
        chk("seed_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("seed_lfsr_c2", 32'(bus.lfsr_rst), 32'd1);
        tick();
        chk("seed_release", 32'(bus.lfsr_rst), 32'd0);
        chk("rampup_state", 32'(bus.state_o), 32'd2);
        ramp(8, 2, 32, 1'b0, -11'sd1024);
        tick();
        chk("active_state", 32'(bus.state_o), 32'd3);
        chk("active_busy", 32'(bus.busy), 32'd0);

        // ACTIVE tracks cfg_shift both ways.
        bus.cfg_shift = 3'd5;
        tick();
        ramp(2, 5, 16, 1'b1, '0);
        bus.cfg_shift = 3'd2;
        tick();
        ramp(5, 2, 16, 1'b1, '0);

        // Disable: ramp 2 -> 8 over 6*RS requests, then IDLE.
        bus.cfg_en = 1'b0;
        tick();
        chk("rampdown_state", 32'(bus.state_o), 32'd4);
        ramp(2, 8, 24, 1'b1, '0);
        wait_state(3'd0, 10, "back_to_idle");
        m_idle = 1'b1;
        prev_m = '0;
        chk("idle_lfsr", 32'(bus.lfsr_rst), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        send(DW'($urandom), 8);

        // Re-enable and ramp up, then partially down to 5.
        bus.cfg_en = 1'b1;
        m_idle = 1'b0;
        wait_state(3'd2, 10, "reenable_rampup");
        ramp(8, 2, 28, 1'b1, '0);
        wait_state(3'd3, 5, "reenable_active");
        bus.cfg_en = 1'b0;
        tick();
        ramp(2, 8, 12, 1'b1, '0);

        // Re-enable at att 5: no reseed, then 1000 idle cycles make no progress.
        bus.cfg_en = 1'b1;
        lfsr_hits = 0;
        valid_hits = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (bus.lfsr_rst) lfsr_hits++;
            if (bus.dith_valid) valid_hits++;
        end
        chk("no_reseed", 32'(lfsr_hits), 32'd0);
        chk("no_req_no_valid", 32'(valid_hits), 32'd0);
        chk("stalled_rampup", 32'(bus.state_o), 32'd2);
        ramp(5, 2, 6, 1'b1, '0);

        // Asynchronous reset mid-ramp.
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(bus.state_o), 32'd0);
        chk("async_rst_lfsr", 32'(bus.lfsr_rst), 32'd1);
        chk("async_rst_dith_o", 32'(bus.dith_o), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_valid", 32'(bus.dith_valid), 32'd0);
        prev_m = '0;
        m_idle = 1'b1;
        bus.cfg_en = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

`ifdef DITHER_HP_SHAPE_EN
        bus.cfg_shift = 3'd0;
        bus.cfg_en = 1'b1;
        m_idle = 1'b0;
        wait_state(3'd2, 10, "shape_rampup");
        ramp(8, 0, 32, 1'b0, '0);
        wait_state(3'd3, 5, "shape_active");
        send(11'sd100, 0);
        send(11'sd300, 0);
        send(-11'sd200, 0);
`endif

        repeat (5) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dither_sequencer.md
Name: dither_sequencer

Overview:
Controls the dither generator that feeds the delta-sigma modulator. Gates the raw dither stream onto sample requests from the modulator and scales it by a configurable right-shift attenuation. Ramps the attenuation gradually on enable, disable and config change so the noise floor does not step. Holds the generator in reset to re-seed it deterministically on every enable.

Parameters:
DW, 11, dither word width (signed, two's complement) on input and output
RAMP_STEP, 64, number of serviced sample requests per one-step attenuation change; legal range >= 1
SEED_CYC, 2, cycles lfsr_rst is held high on enable; legal range >= 1

Ports:
clock  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
dith_i  input  DW  signed raw dither from the generator; sampled only on a serviced request
cfg_en  input  1  level; 1 = dither requested, 0 = dither muted
cfg_shift  input  3  target attenuation; dither_out = dith_i >>> cfg_shift (0..7)
sample_req  input  1  one-cycle pulse from the modulator requesting a dither sample
dith_o  output  DW  signed scaled dither
dith_valid  output  1  one-cycle pulse; dith_o is updated in this cycle
lfsr_rst  output  1  active-high reset to the generator
state_o  output  3  current FSM state encoding
busy  output  1  high in SEED, RAMP_UP and RAMP_DOWN

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE, att = 8 (mute), dith_o = 0, dith_valid = 0, lfsr_rst = 1, busy = 0, step counter = 0.
- Attenuation register att, range 0..8; 8 means output forced to 0.
- Serviced request: sample_req high in any state.
  - Next cycle: dith_o = (att == 8) ? 0 : (dith_i >>> att), arithmetic shift, sign preserved.
  - dith_valid pulses for exactly that cycle, so latency is 1 cycle.
  - Back-to-back requests produce back-to-back valid pulses.
- FSM states and transitions:
  - IDLE (0): lfsr_rst = 1, att = 8. If cfg_en = 1, go to SEED and load the seed counter with SEED_CYC.
  - SEED (1): lfsr_rst = 1. Decrement the counter each cycle; at 0, release lfsr_rst and go to RAMP_UP. If cfg_en drops, return to IDLE.
  - RAMP_UP (2): step counter counts serviced requests. When it reaches RAMP_STEP: clear it and decrement att. When att == cfg_shift, go to ACTIVE. If cfg_en drops, go to RAMP_DOWN without changing att.
  - ACTIVE (3):
    - att tracks cfg_shift in single steps, one step per RAMP_STEP serviced requests, in either direction.
    - The step counter resets whenever att == cfg_shift.
    - If cfg_en drops, go to RAMP_DOWN.
  - RAMP_DOWN (4): increment att every RAMP_STEP serviced requests. When att == 8, go to IDLE. If cfg_en rises again, go to RAMP_UP from the current att without re-seeding.
- Step counter rules:
  - The counter advances only on serviced requests; no requests means no ramp progress.
  - The counter clears on every state change.
- att never goes below cfg_shift when stepping down and never above 8.
- cfg_shift changing during RAMP_UP retargets immediately. If att is already <= the new target, go to ACTIVE next cycle; ACTIVE then steps att toward the target.
- A sample_req arriving in the same cycle as an att step uses the old att. The new att applies from the next request.
- lfsr_rst is registered, glitch-free, and is high in IDLE and SEED only.

Optional Feature:
- Macro DITHER_HP_SHAPE_EN. When defined, dither is first-order high-pass shaped.
  - Register prev = last dith_i taken on a serviced request; reset value 0.
  - shaped = (dith_i - prev) computed at DW+1 bits, then arithmetic >>> 1 back to DW bits.
  - shaped replaces dith_i before attenuation.
  - prev clears to 0 in IDLE.
- When not defined: no prev register, and dith_i feeds attenuation directly.

Decomposition:
- Package dither_pkg holds:
  - state enum IDLE/SEED/RAMP_UP/ACTIVE/RAMP_DOWN (3 bits, values 0..4)
  - ATT_MUTE = 8
  - DW default
- One sub-module, dither_scale: combinational-plus-register datapath (optional shaping, shift, mute, output register, valid pulse). The FSM and counters stay in dither_sequencer.

Test Plan:
- Reset: assert reset_n = 0 mid-ramp -> all outputs to reset values immediately; dith_o = 0, lfsr_rst = 1, state_o = 0.
- Enable with cfg_shift = 2, RAMP_STEP = 4:
  - lfsr_rst is high for exactly 2 cycles after the enable is sampled.
  - Feed requests with dith_i = 11'h400 (-1024).
  - Outputs: 0 for the first 4 requests, then -1024>>>7 = -8, then -16, -32 ... until -256.
  - state_o = 3 after att reaches 2.
- Disable from ACTIVE (att = 2) -> att rises to 8 over 6*RAMP_STEP serviced requests, then dith_o = 0 and state returns to IDLE with lfsr_rst = 1.
- Re-enable during RAMP_DOWN at att = 5 -> no lfsr_rst pulse; ramp resumes downward from 5.
- No sample_req for 1000 cycles in RAMP_UP -> att unchanged and dith_valid never pulses.
- With DITHER_HP_SHAPE_EN, att = 0, dith_i sequence 100, 300, -200 -> dith_o = 50, 100, -250.
